// File: rtl/mau_pkg.sv
// Shared constants for the memory access unit: RV32I load/store width codes
// and the FSM state encoding.
package mau_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_READ  = ST_READ,
        S_WRITE = ST_WRITE,
        S_RESP  = ST_RESP
    } mau_state_e;

    function automatic logic f3_illegal(input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/memory_access_unit_lane_align.sv
// Byte/half lane handling: extracts and extends load data from a memory word,
// and merges store data into a word for read-modify-write.
module lane_align
    import mau_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[7:0];
        case (offset_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        load_data_o = 32'd0;
        case (funct3_i)
            F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
            F3_W:    load_data_o = word_i;
            F3_BU:   load_data_o = {24'd0, byte_sel};
            F3_HU:   load_data_o = {16'd0, half_sel};
            default: load_data_o = 32'd0;
        endcase
    end

    // Sub-word stores keep the untouched lanes of the captured word.
    always_comb begin
        store_data_o = word_i;
        case (funct3_i)
            F3_B: begin
                case (offset_i)
                    2'd0:    store_data_o[7:0]   = wdata_i[7:0];
                    2'd1:    store_data_o[15:8]  = wdata_i[7:0];
                    2'd2:    store_data_o[23:16] = wdata_i[7:0];
                    default: store_data_o[31:24] = wdata_i[7:0];
                endcase
            end
            F3_H: begin
                if (offset_i[1]) store_data_o[31:16] = wdata_i[15:0];
                else             store_data_o[15:0]  = wdata_i[15:0];
            end
            default: store_data_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/memory_access_unit.sv
// CPU-side load/store unit in front of a word-wide data memory with a
// combinational read port; sub-word stores are done as read-modify-write.
module memory_access_unit
    import mau_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [2:0]       req_funct3,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_rdata,
    output logic             resp_error,
    output logic [DEPTH-1:0] mem_read_address,
    input  logic [WIDTH-1:0] mem_read_data,
    output logic [DEPTH-1:0] mem_write_address,
    output logic [WIDTH-1:0] mem_write_data,
    output logic             mem_write_enable,
    output logic [1:0]       mem_write_width,
    output logic [1:0]       dbg_state_o
);

    // Handshakes: a request transfers on a cycle where req_valid && req_ready;
    // a response transfers on a cycle where resp_valid && resp_ready, and the
    // response outputs stay stable while resp_valid is high and resp_ready low.

    mau_state_e       state_q, state_d;
    logic             write_q;
    logic [2:0]       funct3_q;
    logic [DEPTH-1:0] waddr_q;
    logic [1:0]       off_q;
    logic [31:0]      wdata_q;
    logic [31:0]      word_q;
    logic [31:0]      rdata_q;
    logic             error_q;

    logic        accept;
    logic        req_err;
    logic        addr_high_nz;
    logic [31:0] align_word;
    logic [31:0] load_data;
    logic [31:0] store_data;

    assign accept       = (state_q == S_IDLE) && req_valid;
    assign addr_high_nz = (req_addr >> (DEPTH + 2)) != 32'd0;

    always_comb begin
        req_err = f3_illegal(req_funct3) || addr_high_nz;
        if (req_write && ((req_funct3 == F3_BU) || (req_funct3 == F3_HU))) req_err = 1'b1;
        if (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0]) req_err = 1'b1;
        if ((req_funct3 == F3_W) && (req_addr[1:0] != 2'd0)) req_err = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_err)                                 state_d = S_RESP;
                    else if (req_write && (req_funct3 == F3_W)) state_d = S_WRITE;
                    else                                         state_d = S_READ;
                end
            end
            S_READ:  state_d = write_q ? S_WRITE : S_RESP;
            S_WRITE: state_d = S_RESP;
            S_RESP:  if (resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            write_q  <= 1'b0;
            funct3_q <= 3'd0;
            waddr_q  <= '0;
            off_q    <= 2'd0;
            wdata_q  <= 32'd0;
            word_q   <= 32'd0;
            rdata_q  <= 32'd0;
            error_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                write_q  <= req_write;
                funct3_q <= req_funct3;
                waddr_q  <= req_addr[DEPTH+1:2];
                off_q    <= req_addr[1:0];
                wdata_q  <= req_wdata;
                rdata_q  <= 32'd0;
                error_q  <= req_err;
            end
            if (state_q == S_READ) begin
                word_q <= mem_read_data;
                if (!write_q) rdata_q <= load_data;
            end
        end
    end

    // Loads align the live read data; stores merge into the word captured in READ.
    assign align_word = (state_q == S_READ) ? mem_read_data : word_q;

    lane_align u_lane_align (
        .funct3_i     (funct3_q),
        .offset_i     (off_q),
        .word_i       (align_word),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data),
        .store_data_o (store_data)
    );

    assign req_ready         = (state_q == S_IDLE);
    assign resp_valid        = (state_q == S_RESP);
    assign resp_rdata        = rdata_q;
    assign resp_error        = error_q;
    assign mem_read_address  = waddr_q;
    assign mem_write_address = waddr_q;
    assign mem_write_enable  = (state_q == S_WRITE);
    assign mem_write_width   = mem_write_enable ? 2'd3 : 2'd0;
    assign mem_write_data    = mem_write_enable ? store_data : '0;
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit with a behavioural word memory.
module tb_memory_access_unit;

    localparam int DEPTH = 8;
    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [2:0]       req_funct3;
    logic [31:0]      req_addr;
    logic [31:0]      req_wdata;
    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_rdata;
    logic             resp_error;
    logic [DEPTH-1:0] mem_read_address;
    logic [WIDTH-1:0] mem_read_data;
    logic [DEPTH-1:0] mem_write_address;
    logic [WIDTH-1:0] mem_write_data;
    logic             mem_write_enable;
    logic [1:0]       mem_write_width;
    logic [1:0]       dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0]      mem [0:(1<<DEPTH)-1];
    logic             pl_en;
    logic [DEPTH-1:0] pl_addr;
    logic [31:0]      pl_data;
    int               wr_cnt = 0;
    logic [1:0]       last_w_width;
    logic [DEPTH-1:0] last_w_addr;
    logic [31:0]      last_w_data;

    memory_access_unit #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_write         (req_write),
        .req_funct3        (req_funct3),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_rdata        (resp_rdata),
        .resp_error        (resp_error),
        .mem_read_address  (mem_read_address),
        .mem_read_data     (mem_read_data),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
        .mem_write_enable  (mem_write_enable),
        .mem_write_width   (mem_write_width),
        .dbg_state_o       (dbg_state)
    );

    // Clock and memory model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_read_address];

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (mem_write_enable) begin
            mem[mem_write_address] <= mem_write_data;
            wr_cnt       = wr_cnt + 1;
            last_w_width = mem_write_width;
            last_w_addr  = mem_write_address;
            last_w_data  = mem_write_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [DEPTH-1:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Issues one request, waits for its response, optionally stalls it, then retires it.
    task automatic do_req(input string tag, input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input int stall,
                          output logic [31:0] rd, output logic er, output int lat);
        check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_resp_seen"}, {31'd0, resp_valid}, 32'd1);
        rd = resp_rdata;
        er = resp_error;
        for (int i = 0; i < stall; i++) begin
            check({tag, "_stall_valid"}, {31'd0, resp_valid}, 32'd1);
            check({tag, "_stall_rdata"}, resp_rdata, rd);
            check({tag, "_stall_ready"}, {31'd0, req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check({tag, "_retired"}, {31'd0, resp_valid}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        check({tag, "_resp_error"}, {31'd0, resp_error}, 32'd0);
        check({tag, "_we"}, {31'd0, mem_write_enable}, 32'd0);
        check({tag, "_wwidth"}, {30'd0, mem_write_width}, 32'd0);
        check({tag, "_raddr"}, {24'd0, mem_read_address}, 32'd0);
        check({tag, "_waddr"}, {24'd0, mem_write_address}, 32'd0);
        check({tag, "_wdata"}, mem_write_data, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          wr_before;

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
        pl_en = 1'b0; pl_addr = '0; pl_data = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_state", {30'd0, dbg_state}, 32'd0);

        preload(8'd0, 32'h1122_3344);
        preload(8'd1, 32'h0000_80FF);
        preload(8'd2, 32'h1234_8001);
        preload(8'd3, 32'hCAFE_BABE);
        preload(8'd5, 32'hAABB_CCDD);
        preload(8'd7, 32'h0102_0304);

        // LB with sign extension
        do_req("lb", 1'b0, 3'b000, 32'h5, 32'd0, 0, rd, er, lat);
        check("lb_rdata", rd, 32'hFFFF_FF80);
        check("lb_error", {31'd0, er}, 32'd0);
        check("lb_latency", lat, 32'd2);

        preload(8'd1, 32'hBEEF_1234);
        do_req("lhu", 1'b0, 3'b101, 32'h6, 32'd0, 0, rd, er, lat);
        check("lhu_rdata", rd, 32'h0000_BEEF);

        do_req("lh", 1'b0, 3'b001, 32'h8, 32'd0, 0, rd, er, lat);
        check("lh_rdata", rd, 32'hFFFF_8001);

        // LW with the response stalled for 5 cycles
        do_req("lw", 1'b0, 3'b010, 32'hC, 32'd0, 5, rd, er, lat);
        check("lw_rdata", rd, 32'hCAFE_BABE);

        wr_before = wr_cnt;
        do_req("sb", 1'b1, 3'b000, 32'h2, 32'h0000_00AA, 0, rd, er, lat);
        check("sb_writes", wr_cnt - wr_before, 32'd1);
        check("sb_width", {30'd0, last_w_width}, 32'd3);
        check("sb_addr", {24'd0, last_w_addr}, 32'd0);
        check("sb_data", last_w_data, 32'h11AA_3344);
        check("sb_mem", mem[0], 32'h11AA_3344);
        check("sb_latency", lat, 32'd3);
        check("sb_rdata", rd, 32'd0);

        wr_before = wr_cnt;
        do_req("sh", 1'b1, 3'b001, 32'h16, 32'h1234_5A5A, 0, rd, er, lat);
        check("sh_writes", wr_cnt - wr_before, 32'd1);
        check("sh_mem", mem[5], 32'h5A5A_CCDD);

        wr_before = wr_cnt;
        do_req("sw", 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0, rd, er, lat);
        check("sw_writes", wr_cnt - wr_before, 32'd1);
        check("sw_mem", mem[4], 32'hDEAD_BEEF);
        check("sw_latency", lat, 32'd2);
        check("sw_error", {31'd0, er}, 32'd0);

        // Faulting accesses: misaligned SW, out-of-range, illegal funct3, store BU
        wr_before = wr_cnt;
        do_req("sw_mis", 1'b1, 3'b010, 32'h3, 32'hFFFF_FFFF, 0, rd, er, lat);
        check("sw_mis_error", {31'd0, er}, 32'd1);
        check("sw_mis_latency", lat, 32'd1);
        check("sw_mis_rdata", rd, 32'd0);
        check("sw_mis_writes", wr_cnt - wr_before, 32'd0);

        do_req("oor", 1'b0, 3'b010, 32'h400, 32'd0, 0, rd, er, lat);
        check("oor_error", {31'd0, er}, 32'd1);
        check("oor_rdata", rd, 32'd0);

        do_req("f3bad", 1'b0, 3'b011, 32'h0, 32'd0, 0, rd, er, lat);
        check("f3bad_error", {31'd0, er}, 32'd1);

        do_req("sbu", 1'b1, 3'b100, 32'h1, 32'h55, 0, rd, er, lat);
        check("sbu_error", {31'd0, er}, 32'd1);
        check("fault_writes", wr_cnt - wr_before, 32'd0);

        // Reset while an SH sits in WRITE
        wr_before = wr_cnt;
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b001;
        req_addr = 32'h1C; req_wdata = 32'h0000_FFFF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("abort_in_read", {30'd0, dbg_state}, 32'd1);
        @(posedge clk); #1;
        check("abort_in_write", {30'd0, dbg_state}, 32'd2);
        rst_n = 1'b0;
        #1;
        check("abort_we_drop", {31'd0, mem_write_enable}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("abort_writes", wr_cnt - wr_before, 32'd0);
        check("abort_mem", mem[7], 32'h0102_0304);
        check_reset_outputs("abort");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_req_ready", {31'd0, req_ready}, 32'd1);
        check("abort_state", {30'd0, dbg_state}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
